// File: rtl/led_blink.sv
// -----------------------------------------------------------------------------
// led_blink
//   Free-running LED blinker. One half-period counter divides clk. Whenever
//   the half-period chosen by the 2-bit switch input elapses, the LED toggles.
//   A change of the switch value restarts the current half-period, so the new
//   rate starts from a clean count.
//
// Ports
//   clk  in   1  system clock, all logic on the rising edge
//   R    in   1  synchronous active-high reset
//   sw   in   2  rate select (00 slowest .. 11 fastest), quasi-static
//   LED  out  1  registered blink output
//
// Parameters
//   CNT_W           width of the half-period counter
//   DIV0..DIV3      half-period in clk cycles for sw = 00/01/10/11,
//                   each must lie in 1 .. 2**CNT_W
//
// Build option
//   LED_BLINK_SW_SYNC_EN  when defined, sw passes through a 2-flop
//                         synchronizer (reset to 00) before use, adding two
//                         cycles of latency to every switch change. When
//                         undefined, sw is used directly and must be
//                         synchronous to clk.
// -----------------------------------------------------------------------------
module led_blink #(
   parameter int CNT_W = 26,
   parameter int DIV0  = 50000000,
   parameter int DIV1  = 25000000,
   parameter int DIV2  = 12500000,
   parameter int DIV3  = 6250000
) (
   input  logic       clk,
   input  logic       R,
   input  logic [1:0] sw,
   output logic       LED
);

   localparam longint MAX_DIV = longint'(1) << CNT_W;

   // Elaboration-time range checks on the divider settings.
   if (DIV0 < 1 || longint'(DIV0) > MAX_DIV) begin : g_bad_div0
      $error("led_blink: DIV0 out of range 1..2**CNT_W");
   end
   if (DIV1 < 1 || longint'(DIV1) > MAX_DIV) begin : g_bad_div1
      $error("led_blink: DIV1 out of range 1..2**CNT_W");
   end
   if (DIV2 < 1 || longint'(DIV2) > MAX_DIV) begin : g_bad_div2
      $error("led_blink: DIV2 out of range 1..2**CNT_W");
   end
   if (DIV3 < 1 || longint'(DIV3) > MAX_DIV) begin : g_bad_div3
      $error("led_blink: DIV3 out of range 1..2**CNT_W");
   end

   // Terminal counts. A half-period of 2**CNT_W still fits because only
   // limit-1 is ever stored or compared.
   localparam logic [CNT_W-1:0] LIM0_M1 = CNT_W'(DIV0 - 1);
   localparam logic [CNT_W-1:0] LIM1_M1 = CNT_W'(DIV1 - 1);
   localparam logic [CNT_W-1:0] LIM2_M1 = CNT_W'(DIV2 - 1);
   localparam logic [CNT_W-1:0] LIM3_M1 = CNT_W'(DIV3 - 1);

   logic [1:0]       w_sw_eff;
   logic [CNT_W-1:0] w_limit_m1;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sw_prev;
   logic             r_led;

`ifdef LED_BLINK_SW_SYNC_EN
   logic [1:0] r_sw_meta;
   logic [1:0] r_sw_sync;

   always_ff @(posedge clk) begin
      if (R) begin
         r_sw_meta <= 2'b00;
         r_sw_sync <= 2'b00;
      end else begin
         r_sw_meta <= sw;
         r_sw_sync <= r_sw_meta;
      end
   end

   assign w_sw_eff = r_sw_sync;
`else
   assign w_sw_eff = sw;
`endif

   // NOTE: the output gets a value before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_limit_m1 = LIM0_M1;
      case (w_sw_eff)
         2'b00:   w_limit_m1 = LIM0_M1;
         2'b01:   w_limit_m1 = LIM1_M1;
         2'b10:   w_limit_m1 = LIM2_M1;
         default: w_limit_m1 = LIM3_M1;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      r_sw_prev <= w_sw_eff;
      if (R) begin
         r_cnt <= '0;
         r_led <= 1'b0;
      end else if (w_sw_eff != r_sw_prev) begin
         // Rate change wins over a coincident terminal count: restart the
         // half-period and keep the LED level.
         r_cnt <= '0;
      end else if (r_cnt == w_limit_m1) begin
         r_cnt <= '0;
         r_led <= ~r_led;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign LED = r_led;

endmodule

// File: tb/tb_led_blink.sv
// -----------------------------------------------------------------------------
// tb_led_blink
//   Directed self-checking bench for led_blink with small dividers
//   (DIV0=4, DIV1=3, DIV2=2, DIV3=1, CNT_W=3). LED is sampled 1 ns after
//   each rising edge; inputs change right after sampling.
//   With LED_BLINK_SW_SYNC_EN defined, switch changes are applied two edges
//   earlier so the restart lands on the same edge as in the plain build.
// -----------------------------------------------------------------------------
module tb_led_blink;

`ifdef LED_BLINK_SW_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic       clk;
   logic       R;
   logic [1:0] sw;
   logic       LED;

   int n_asserts = 0;
   int n_fail    = 0;

   led_blink #(
      .CNT_W (3),
      .DIV0  (4),
      .DIV1  (3),
      .DIV2  (2),
      .DIV3  (1)
   ) dut (
      .clk (clk),
      .R   (R),
      .sw  (sw),
      .LED (LED)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and compare LED against the expected level.
   task automatic step(input string tag, input logic exp);
      @(posedge clk);
      #1;
      n_asserts++;
      assert (LED === exp) else begin
         n_fail++;
         $error("FAIL %s: LED=%b expected %b", tag, LED, exp);
      end
   endtask

   task automatic run(input string tag, input int n, input logic exp);
      for (int i = 0; i < n; i++) step(tag, exp);
   endtask

   initial begin
      R  = 1'b1;
      sw = 2'b00;

      // Reset held for two edges.
      step("reset_e1", 1'b0);
      step("reset_e2", 1'b0);
      R = 1'b0;

      // First toggle on the 4th edge after release.
      run ("first_low", 3, 1'b0);
      step("first_toggle", 1'b1);

      // Steady sw=00: 4 high / 4 low, three periods.
      for (int p = 0; p < 3; p++) begin
         run ("div0_high", 3, 1'b1);
         run ("div0_low",  4, 1'b0);
         step("div0_rise", 1'b1);
      end

      // Rate change 00->01 with cnt=2; the change edge holds LED high.
      if (SYNC_LAT == 2) sw = 2'b01;
      step("pre_chg_cnt1", 1'b1);
      step("pre_chg_cnt2", 1'b1);
      sw = 2'b01;
      step("chg01_hold", 1'b1);
      run ("div1_high", 2, 1'b1);
      step("div1_fall", 1'b0);
      run ("div1_low",  2, 1'b0);
      step("div1_rise", 1'b1);
      run ("div1_high2", 2, 1'b1);
      step("div1_fall2", 1'b0);

      // Change to 10 (in the synchronized build this coincides with a
      // terminal count of the old rate, which must not toggle).
      sw = 2'b10;
      run ("chg10_wait", SYNC_LAT, 1'b0);
      step("chg10_hold", 1'b0);
      step("div2_a", 1'b0);
      step("div2_b", 1'b1);
      step("div2_c", 1'b1);
      step("div2_d", 1'b0);
      step("div2_e", 1'b0);
      step("div2_f", 1'b1);

      // Change to 11 exactly on a terminal count: no toggle on that edge.
      step("pre11_cnt1", 1'b1);
      if (SYNC_LAT == 2) sw = 2'b11;
      step("pre11_fall", 1'b0);
      step("pre11_cnt1b", 1'b0);
      if (SYNC_LAT == 0) sw = 2'b11;
      step("chg11_term_hold", 1'b0);
      step("div3_a", 1'b1);
      step("div3_b", 1'b0);
      if (SYNC_LAT == 2) sw = 2'b00;
      step("div3_c", 1'b1);
      step("div3_d", 1'b0);

      // Back to 00, then reset while LED=1 at cnt=1.
      if (SYNC_LAT == 0) sw = 2'b00;
      step("chg00_hold", 1'b0);
      run ("div0b_low", 3, 1'b0);
      step("div0b_rise", 1'b1);
      step("div0b_cnt1", 1'b1);
      R = 1'b1;
      step("midreset_e1", 1'b0);
      step("midreset_e2", 1'b0);
      step("midreset_e3", 1'b0);
      R = 1'b0;
      run ("rel_low", 3, 1'b0);
      step("rel_toggle", 1'b1);
      step("rel_high", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
